// File: rtl/bp_fe_itlb_pipe.sv
// rtl/bp_fe_itlb_pipe.sv - fetch translation pipe: ITLB, fault checks, poison, credit-protected response FIFO
// Optional feature macro: BP_FE_ITLB_PIPE_PERF_EN (saturating perf counters; ports tie to 0 when undefined)
// Ports:
//   clk_i, reset_n_i                      clock, async active-low reset
//   cmd_v_i/cmd_op_i/cmd_vtag_i/cmd_ptag_i/cmd_u_i/cmd_x_i, cmd_ready_o   fetch/fill/fence command
//   translation_en_i, priv_i, poison_i    stage-0 translation controls, fetch squash
//   icache_ptag_o, icache_ptag_v_o        stage-1 physical tag to icache
//   data_i, data_v_i                      stage-2 icache data / hit
//   resp_v_o, resp_ready_i, resp_data_o, resp_flags_o   response FIFO head
//   perf_fetch_o, perf_tlb_miss_o, perf_ic_miss_o       perf counters
module bp_fe_itlb_pipe #(
    parameter int vtag_width_p     = 27,
    parameter int ptag_width_p     = 28,
    parameter int els_p            = 8,
    parameter int resp_fifo_els_p  = 4,
    parameter int instr_width_p    = 32,
    parameter int did_width_p      = 3,
    parameter int dram_base_ptag_p = 'h80000
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     cmd_v_i,
    input  logic [1:0]               cmd_op_i,
    input  logic [vtag_width_p-1:0]  cmd_vtag_i,
    input  logic [ptag_width_p-1:0]  cmd_ptag_i,
    input  logic                     cmd_u_i,
    input  logic                     cmd_x_i,
    output logic                     cmd_ready_o,
    input  logic                     translation_en_i,
    input  logic [1:0]               priv_i,
    input  logic                     poison_i,
    output logic [ptag_width_p-1:0]  icache_ptag_o,
    output logic                     icache_ptag_v_o,
    input  logic [instr_width_p-1:0] data_i,
    input  logic                     data_v_i,
    output logic                     resp_v_o,
    input  logic                     resp_ready_i,
    output logic [instr_width_p-1:0] resp_data_o,
    output logic [3:0]               resp_flags_o,
    output logic [31:0]              perf_fetch_o,
    output logic [31:0]              perf_tlb_miss_o,
    output logic [31:0]              perf_ic_miss_o
);
    localparam int idx_w_lp = $clog2(els_p);
    localparam int ptr_w_lp = $clog2(resp_fifo_els_p);
    localparam int cnt_w_lp = $clog2(resp_fifo_els_p + 1);
    localparam int crd_w_lp = cnt_w_lp + 1;
    localparam logic [1:0] op_fetch_lp = 2'd0;
    localparam logic [1:0] op_fill_lp  = 2'd1;
    localparam logic [1:0] op_fence_lp = 2'd2;
    localparam logic [1:0] priv_u_lp   = 2'd0;
    localparam logic [1:0] priv_s_lp   = 2'd1;
    localparam logic [ptag_width_p-1:0] dram_base_lp = ptag_width_p'(dram_base_ptag_p);
    localparam logic [ptr_w_lp-1:0]     ptr_last_lp  = ptr_w_lp'(resp_fifo_els_p - 1);

    logic [vtag_width_p-1:0] tlb_vtag [els_p];
    logic [ptag_width_p-1:0] tlb_ptag [els_p];
    logic [els_p-1:0]        tlb_v, tlb_u, tlb_x;
    logic [idx_w_lp-1:0]     victim, hit_idx, inv_idx, fill_idx;
    logic                    hit, inv_found;

    logic ready_r, accept, do_fetch, do_fill, do_fence;
    logic v1, v2, miss1, pf1, af1, miss2, pf2, af2, clean2;
    logic [ptag_width_p-1:0] ptag1, s0_ptag;
    logic s0_miss, s0_pf, s0_af;

    logic [instr_width_p-1:0] fifo_data [resp_fifo_els_p];
    logic [3:0]               fifo_flags [resp_fifo_els_p];
    logic [ptr_w_lp-1:0]      wr_ptr, rd_ptr;
    logic [cnt_w_lp-1:0]      fifo_count;
    logic [crd_w_lp-1:0]      credit_used;
    logic push, pop;
    logic [instr_width_p-1:0] push_data;
    logic [3:0]               push_flags;

    // Credit counts every fetch that already owns a FIFO slot, so a push can never find the FIFO full.
    assign credit_used = crd_w_lp'(fifo_count) + crd_w_lp'(v1) + crd_w_lp'(v2);
    assign cmd_ready_o = ready_r & (credit_used < crd_w_lp'(resp_fifo_els_p));
    assign accept      = cmd_v_i & cmd_ready_o;
    assign do_fetch    = accept & (cmd_op_i == op_fetch_lp) & ~poison_i;
    assign do_fill     = accept & (cmd_op_i == op_fill_lp);
    assign do_fence    = accept & (cmd_op_i == op_fence_lp);

    // Lowest-index match and lowest-index free slot.
    always_comb begin
        hit       = 1'b0;
        hit_idx   = '0;
        inv_found = 1'b0;
        inv_idx   = '0;
        for (int i = els_p - 1; i >= 0; i--) begin
            if (tlb_v[i] && (tlb_vtag[i] == cmd_vtag_i)) begin
                hit     = 1'b1;
                hit_idx = idx_w_lp'(i);
            end
            if (!tlb_v[i]) begin
                inv_found = 1'b1;
                inv_idx   = idx_w_lp'(i);
            end
        end
    end

    assign fill_idx = hit ? hit_idx : (inv_found ? inv_idx : victim);

    assign s0_ptag = translation_en_i ? tlb_ptag[hit_idx] : ptag_width_p'(cmd_vtag_i);
    assign s0_miss = translation_en_i & ~hit;
    assign s0_pf   = translation_en_i & hit &
                     (((priv_i == priv_s_lp) & tlb_u[hit_idx]) |
                      ((priv_i == priv_u_lp) & ~tlb_u[hit_idx]) | ~tlb_x[hit_idx]);
    assign s0_af   = ~s0_miss & ((s0_ptag[ptag_width_p-1 -: did_width_p] != '0) |
                                 (s0_ptag < dram_base_lp));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            tlb_v  <= '0;
            victim <= '0;
        end else if (do_fence) begin
            tlb_v  <= '0;
            victim <= '0;
        end else if (do_fill) begin
            tlb_v[fill_idx] <= 1'b1;
            if (!hit && !inv_found) victim <= victim + idx_w_lp'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_fill) begin
            tlb_vtag[fill_idx] <= cmd_vtag_i;
            tlb_ptag[fill_idx] <= cmd_ptag_i;
            tlb_u[fill_idx]    <= cmd_u_i;
            tlb_x[fill_idx]    <= cmd_x_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ready_r <= 1'b0;
            v1      <= 1'b0;
            v2      <= 1'b0;
            ptag1   <= '0;
            miss1   <= 1'b0;
            pf1     <= 1'b0;
            af1     <= 1'b0;
            miss2   <= 1'b0;
            pf2     <= 1'b0;
            af2     <= 1'b0;
        end else begin
            ready_r <= 1'b1;
            v1      <= do_fetch;
            v2      <= v1 & ~poison_i;
            if (do_fetch) begin
                ptag1 <= s0_ptag;
                miss1 <= s0_miss;
                pf1   <= s0_pf;
                af1   <= s0_af;
            end
            miss2 <= miss1;
            pf2   <= pf1;
            af2   <= af1;
        end
    end

    assign icache_ptag_o   = v1 ? ptag1 : '0;
    assign icache_ptag_v_o = v1 & ~poison_i & ~miss1 & ~pf1 & ~af1;

    assign clean2     = ~(miss2 | pf2 | af2);
    assign push       = v2 & ~poison_i;
    assign push_flags = {af2, pf2, miss2, clean2 & ~data_v_i};
    assign push_data  = (clean2 & data_v_i) ? data_i : '0;
    assign pop        = resp_v_o & resp_ready_i;

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_data[wr_ptr]  <= push_data;
            fifo_flags[wr_ptr] <= push_flags;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == ptr_last_lp) ? '0 : wr_ptr + ptr_w_lp'(1);
            if (pop)  rd_ptr <= (rd_ptr == ptr_last_lp) ? '0 : rd_ptr + ptr_w_lp'(1);
            if (push && !pop)      fifo_count <= fifo_count + cnt_w_lp'(1);
            else if (pop && !push) fifo_count <= fifo_count - cnt_w_lp'(1);
        end
    end

    assign resp_v_o     = (fifo_count != '0);
    assign resp_data_o  = resp_v_o ? fifo_data[rd_ptr] : '0;
    assign resp_flags_o = resp_v_o ? fifo_flags[rd_ptr] : 4'b0000;

`ifdef BP_FE_ITLB_PIPE_PERF_EN
    logic [31:0] perf_fetch_r, perf_tlb_r, perf_ic_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            perf_fetch_r <= '0;
            perf_tlb_r   <= '0;
            perf_ic_r    <= '0;
        end else if (push) begin
            if (perf_fetch_r != 32'hFFFF_FFFF) perf_fetch_r <= perf_fetch_r + 32'd1;
            if (push_flags[1] && (perf_tlb_r != 32'hFFFF_FFFF)) perf_tlb_r <= perf_tlb_r + 32'd1;
            if (push_flags[0] && (perf_ic_r != 32'hFFFF_FFFF))  perf_ic_r  <= perf_ic_r + 32'd1;
        end
    end

    assign perf_fetch_o    = perf_fetch_r;
    assign perf_tlb_miss_o = perf_tlb_r;
    assign perf_ic_miss_o  = perf_ic_r;
`else
    assign perf_fetch_o    = 32'd0;
    assign perf_tlb_miss_o = 32'd0;
    assign perf_ic_miss_o  = 32'd0;
`endif

endmodule

// File: tb/tb_bp_fe_itlb_pipe.sv
// tb/tb_bp_fe_itlb_pipe.sv - directed self-checking bench for bp_fe_itlb_pipe
module tb_bp_fe_itlb_pipe;
    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        cmd_v_i;
    logic [1:0]  cmd_op_i;
    logic [26:0] cmd_vtag_i;
    logic [27:0] cmd_ptag_i;
    logic        cmd_u_i, cmd_x_i;
    logic        cmd_ready_o;
    logic        translation_en_i;
    logic [1:0]  priv_i;
    logic        poison_i;
    logic [27:0] icache_ptag_o;
    logic        icache_ptag_v_o;
    logic [31:0] data_i;
    logic        data_v_i;
    logic        resp_v_o;
    logic        resp_ready_i;
    logic [31:0] resp_data_o;
    logic [3:0]  resp_flags_o;
    logic [31:0] perf_fetch_o, perf_tlb_miss_o, perf_ic_miss_o;

    int checks = 0;
    int failures = 0;

    logic        s1_v, s2_v;
    logic [31:0] s1_d, s2_d;
    logic [31:0] popped[$];

    bp_fe_itlb_pipe dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .cmd_v_i(cmd_v_i), .cmd_op_i(cmd_op_i), .cmd_vtag_i(cmd_vtag_i), .cmd_ptag_i(cmd_ptag_i),
        .cmd_u_i(cmd_u_i), .cmd_x_i(cmd_x_i), .cmd_ready_o(cmd_ready_o),
        .translation_en_i(translation_en_i), .priv_i(priv_i), .poison_i(poison_i),
        .icache_ptag_o(icache_ptag_o), .icache_ptag_v_o(icache_ptag_v_o),
        .data_i(data_i), .data_v_i(data_v_i),
        .resp_v_o(resp_v_o), .resp_ready_i(resp_ready_i), .resp_data_o(resp_data_o),
        .resp_flags_o(resp_flags_o),
        .perf_fetch_o(perf_fetch_o), .perf_tlb_miss_o(perf_tlb_miss_o), .perf_ic_miss_o(perf_ic_miss_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [26:0] vtag, input logic [27:0] ptag,
                         input logic u, input logic x, output logic rdy);
        cmd_v_i = 1'b1; cmd_op_i = op; cmd_vtag_i = vtag; cmd_ptag_i = ptag; cmd_u_i = u; cmd_x_i = x;
        rdy = cmd_ready_o;
        tick();
        cmd_v_i = 1'b0;
    endtask

    task automatic fetch_one(input logic [26:0] vtag, input logic dv, input logic [31:0] d,
                             output logic rdy, output logic [27:0] pt, output logic pv,
                             output logic rv2, output logic rv3, output logic [31:0] rd,
                             output logic [3:0] rf);
        cmd_v_i = 1'b1; cmd_op_i = 2'd0; cmd_vtag_i = vtag;
        rdy = cmd_ready_o;
        tick();
        cmd_v_i = 1'b0;
        pt = icache_ptag_o; pv = icache_ptag_v_o;
        tick();
        data_i = d; data_v_i = dv; rv2 = resp_v_o;
        tick();
        data_i = 32'h0; data_v_i = 1'b0;
        rv3 = resp_v_o; rd = resp_data_o; rf = resp_flags_o;
        resp_ready_i = 1'b1;
        tick();
        resp_ready_i = 1'b0;
    endtask

    // One cycle of streaming fetches; the bench plays icache, returning {C0, vtag[23:0]} in stage 2.
    task automatic step(output logic acc);
        data_v_i = s2_v; data_i = s2_v ? s2_d : 32'h0;
        acc = cmd_v_i & cmd_ready_o;
        if (resp_ready_i && resp_v_o) popped.push_back(resp_data_o);
        tick();
        s2_v = s1_v; s2_d = s1_d;
        s1_v = acc && (cmd_op_i == 2'd0);
        s1_d = {8'hC0, cmd_vtag_i[23:0]};
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        tick(); tick();
        checks++; if (cmd_ready_o !== 1'b0) begin failures++; $display("FAIL rst_ready got=%0b exp=0", cmd_ready_o); end
        checks++; if (resp_v_o !== 1'b0) begin failures++; $display("FAIL rst_resp_v got=%0b exp=0", resp_v_o); end
        checks++; if (icache_ptag_v_o !== 1'b0) begin failures++; $display("FAIL rst_ptag_v got=%0b exp=0", icache_ptag_v_o); end
        checks++; if (resp_data_o !== 32'h0 || resp_flags_o !== 4'h0) begin failures++; $display("FAIL rst_data got=%0h/%0h exp=0/0", resp_data_o, resp_flags_o); end
        checks++; if (perf_fetch_o !== 32'h0) begin failures++; $display("FAIL rst_perf got=%0h exp=0", perf_fetch_o); end
        reset_n_i = 1'b1;
        checks++; if (cmd_ready_o !== 1'b0) begin failures++; $display("FAIL ready_before_clk got=%0b exp=0", cmd_ready_o); end
        tick();
        checks++; if (cmd_ready_o !== 1'b1) begin failures++; $display("FAIL ready_after_clk got=%0b exp=1", cmd_ready_o); end
    endtask

    task automatic test_translation_off();
        logic rdy, pv, rv2, rv3; logic [27:0] pt; logic [31:0] rd; logic [3:0] rf;
        translation_en_i = 1'b0; priv_i = 2'd1;
        fetch_one(27'h80001, 1'b1, 32'h13, rdy, pt, pv, rv2, rv3, rd, rf);
        checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL off_ready got=%0b exp=1", rdy); end
        checks++; if (pt !== 28'h80001 || pv !== 1'b1) begin failures++; $display("FAIL off_ptag got=%0h/%0b exp=80001/1", pt, pv); end
        checks++; if (rv2 !== 1'b0) begin failures++; $display("FAIL off_early_resp got=%0b exp=0", rv2); end
        checks++; if (rv3 !== 1'b1) begin failures++; $display("FAIL off_latency3 got=%0b exp=1", rv3); end
        checks++; if (rd !== 32'h13 || rf !== 4'b0000) begin failures++; $display("FAIL off_resp got=%0h/%0b exp=13/0000", rd, rf); end
    endtask

    task automatic test_translation_on();
        logic rdy, pv, rv2, rv3; logic [27:0] pt; logic [31:0] rd; logic [3:0] rf;
        translation_en_i = 1'b1; priv_i = 2'd1;
        fetch_one(27'h12, 1'b1, 32'h77, rdy, pt, pv, rv2, rv3, rd, rf);
        checks++; if (pv !== 1'b0) begin failures++; $display("FAIL miss_ptag_v got=%0b exp=0", pv); end
        checks++; if (rv3 !== 1'b1 || rf !== 4'b0010 || rd !== 32'h0) begin failures++; $display("FAIL miss_resp got=%0b/%0b/%0h exp=1/0010/0", rv3, rf, rd); end
        issue(2'd1, 27'h12, 28'h80010, 1'b0, 1'b1, rdy);
        checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL fill_ready got=%0b exp=1", rdy); end
        fetch_one(27'h12, 1'b1, 32'hABCD, rdy, pt, pv, rv2, rv3, rd, rf);
        checks++; if (pt !== 28'h80010 || pv !== 1'b1) begin failures++; $display("FAIL hit_ptag got=%0h/%0b exp=80010/1", pt, pv); end
        checks++; if (rf !== 4'b0000 || rd !== 32'hABCD) begin failures++; $display("FAIL hit_resp got=%0b/%0h exp=0000/abcd", rf, rd); end
        fetch_one(27'h12, 1'b0, 32'hABCD, rdy, pt, pv, rv2, rv3, rd, rf);
        checks++; if (rf !== 4'b0001 || rd !== 32'h0) begin failures++; $display("FAIL icmiss_resp got=%0b/%0h exp=0001/0", rf, rd); end
    endtask

    task automatic test_faults();
        logic rdy, pv, rv2, rv3; logic [27:0] pt; logic [31:0] rd; logic [3:0] rf;
        translation_en_i = 1'b1; priv_i = 2'd1;
        issue(2'd1, 27'h20, 28'h00400, 1'b0, 1'b1, rdy);
        issue(2'd1, 27'h21, 28'h8000000, 1'b0, 1'b1, rdy);
        issue(2'd1, 27'h22, 28'h80022, 1'b0, 1'b1, rdy);
        issue(2'd1, 27'h23, 28'h80023, 1'b0, 1'b0, rdy);
        fetch_one(27'h20, 1'b1, 32'h1, rdy, pt, pv, rv2, rv3, rd, rf);
        checks++; if (rf !== 4'b1000 || pv !== 1'b0 || rd !== 32'h0) begin failures++; $display("FAIL af_low got=%0b/%0b/%0h exp=1000/0/0", rf, pv, rd); end
        fetch_one(27'h21, 1'b1, 32'h1, rdy, pt, pv, rv2, rv3, rd, rf);
        checks++; if (rf !== 4'b1000) begin failures++; $display("FAIL af_did got=%0b exp=1000", rf); end
        priv_i = 2'd0;
        fetch_one(27'h22, 1'b1, 32'h1, rdy, pt, pv, rv2, rv3, rd, rf);
        checks++; if (rf !== 4'b0100 || pv !== 1'b0) begin failures++; $display("FAIL pf_user got=%0b/%0b exp=0100/0", rf, pv); end
        priv_i = 2'd1;
        fetch_one(27'h23, 1'b1, 32'h1, rdy, pt, pv, rv2, rv3, rd, rf);
        checks++; if (rf !== 4'b0100) begin failures++; $display("FAIL pf_noexec got=%0b exp=0100", rf); end
    endtask

    task automatic test_replacement();
        logic rdy, pv, rv2, rv3; logic [27:0] pt; logic [31:0] rd; logic [3:0] rf;
        logic [3:0] exp_f; logic [27:0] exp_p;
        translation_en_i = 1'b1; priv_i = 2'd1;
        issue(2'd2, 27'h0, 28'h0, 1'b0, 1'b0, rdy);
        for (int i = 0; i < 9; i++) issue(2'd1, 27'(32'h100 + i), 28'(32'h80100 + i), 1'b0, 1'b1, rdy);
        issue(2'd1, 27'h104, 28'h80999, 1'b0, 1'b1, rdy);
        for (int i = 0; i < 9; i++) begin
            fetch_one(27'(32'h100 + i), 1'b1, 32'h1000 + i, rdy, pt, pv, rv2, rv3, rd, rf);
            exp_f = (i == 0) ? 4'b0010 : 4'b0000;
            exp_p = (i == 4) ? 28'h80999 : 28'(32'h80100 + i);
            checks++; if (rf !== exp_f) begin failures++; $display("FAIL repl_flags[%0d] got=%0b exp=%0b", i, rf, exp_f); end
            if (i != 0) begin
                checks++; if (pt !== exp_p) begin failures++; $display("FAIL repl_ptag[%0d] got=%0h exp=%0h", i, pt, exp_p); end
            end
        end
        issue(2'd2, 27'h0, 28'h0, 1'b0, 1'b0, rdy);
        fetch_one(27'h108, 1'b1, 32'h1, rdy, pt, pv, rv2, rv3, rd, rf);
        checks++; if (rf !== 4'b0010) begin failures++; $display("FAIL fence_miss got=%0b exp=0010", rf); end
    endtask

    task automatic test_back_to_back();
        logic acc; int n_acc; logic [26:0] vt;
        translation_en_i = 1'b0; resp_ready_i = 1'b0;
        s1_v = 1'b0; s2_v = 1'b0; popped.delete(); n_acc = 0;
        vt = 27'h80040; cmd_v_i = 1'b1; cmd_op_i = 2'd0; cmd_vtag_i = vt;
        for (int k = 0; k < 8; k++) begin
            step(acc);
            if (acc) begin n_acc++; vt = vt + 27'd1; cmd_vtag_i = vt; end
        end
        checks++; if (n_acc != 4) begin failures++; $display("FAIL b2b_accepted got=%0d exp=4", n_acc); end
        checks++; if (cmd_ready_o !== 1'b0) begin failures++; $display("FAIL b2b_full_ready got=%0b exp=0", cmd_ready_o); end
        checks++; if (resp_data_o !== 32'hC0080040 || resp_flags_o !== 4'b0000) begin failures++; $display("FAIL b2b_head got=%0h/%0b exp=c0080040/0000", resp_data_o, resp_flags_o); end
        resp_ready_i = 1'b1;
        step(acc);
        resp_ready_i = 1'b0;
        checks++; if (acc !== 1'b0 || cmd_ready_o !== 1'b1) begin failures++; $display("FAIL b2b_stall got=%0b/%0b exp=0/1", acc, cmd_ready_o); end
        for (int k = 0; k < 4; k++) begin
            step(acc);
            if (acc) begin n_acc++; cmd_v_i = 1'b0; end
        end
        cmd_v_i = 1'b0;
        checks++; if (n_acc != 5 || cmd_ready_o !== 1'b0) begin failures++; $display("FAIL b2b_refill got=%0d/%0b exp=5/0", n_acc, cmd_ready_o); end
        resp_ready_i = 1'b1;
        for (int k = 0; k < 5; k++) step(acc);
        resp_ready_i = 1'b0; data_v_i = 1'b0; data_i = 32'h0;
        checks++; if (popped.size() != 5) begin failures++; $display("FAIL b2b_count got=%0d exp=5", popped.size()); end
        for (int k = 0; k < popped.size(); k++) begin
            checks++; if (popped[k] !== 32'hC0080040 + k) begin failures++; $display("FAIL b2b_order[%0d] got=%0h exp=%0h", k, popped[k], 32'hC0080040 + k); end
        end
        checks++; if (resp_v_o !== 1'b0) begin failures++; $display("FAIL b2b_drained got=%0b exp=0", resp_v_o); end
    endtask

    task automatic test_poison();
        logic rdy, pv, rv2, rv3; logic [27:0] pt; logic [31:0] rd; logic [3:0] rf;
        translation_en_i = 1'b0;
        cmd_v_i = 1'b1; cmd_op_i = 2'd0; cmd_vtag_i = 27'h80050;
        tick(); cmd_v_i = 1'b0; poison_i = 1'b1;
        tick(); poison_i = 1'b0; data_v_i = 1'b1; data_i = 32'h99;
        tick(); data_v_i = 1'b0;
        checks++; if (resp_v_o !== 1'b0) begin failures++; $display("FAIL poison_n1 got=%0b exp=0", resp_v_o); end
        tick();
        checks++; if (resp_v_o !== 1'b0) begin failures++; $display("FAIL poison_n1_late got=%0b exp=0", resp_v_o); end
        cmd_v_i = 1'b1;
        tick(); cmd_v_i = 1'b0;
        tick(); poison_i = 1'b1; data_v_i = 1'b1;
        tick(); poison_i = 1'b0; data_v_i = 1'b0;
        checks++; if (resp_v_o !== 1'b0) begin failures++; $display("FAIL poison_n2 got=%0b exp=0", resp_v_o); end
        tick();
        checks++; if (resp_v_o !== 1'b0 || cmd_ready_o !== 1'b1) begin failures++; $display("FAIL poison_n2_late got=%0b/%0b exp=0/1", resp_v_o, cmd_ready_o); end
        translation_en_i = 1'b1; priv_i = 2'd1;
        poison_i = 1'b1;
        issue(2'd1, 27'h200, 28'h80200, 1'b0, 1'b1, rdy);
        poison_i = 1'b0;
        fetch_one(27'h200, 1'b1, 32'h5, rdy, pt, pv, rv2, rv3, rd, rf);
        checks++; if (rv3 !== 1'b1 || rf !== 4'b0000 || pt !== 28'h80200) begin failures++; $display("FAIL poison_fill got=%0b/%0b/%0h exp=1/0000/80200", rv3, rf, pt); end
    endtask

    task automatic test_reset_midflight();
        translation_en_i = 1'b0; resp_ready_i = 1'b0;
        data_v_i = 1'b1; data_i = 32'h55;
        cmd_v_i = 1'b1; cmd_op_i = 2'd0; cmd_vtag_i = 27'h80060;
        tick(); tick(); tick();
        cmd_v_i = 1'b0;
        tick();
        checks++; if (resp_v_o !== 1'b1) begin failures++; $display("FAIL mid_pre got=%0b exp=1", resp_v_o); end
        #3 reset_n_i = 1'b0;
        #1;
        checks++; if (resp_v_o !== 1'b0 || cmd_ready_o !== 1'b0 || icache_ptag_v_o !== 1'b0) begin failures++; $display("FAIL mid_reset got=%0b/%0b/%0b exp=0/0/0", resp_v_o, cmd_ready_o, icache_ptag_v_o); end
        tick();
        reset_n_i = 1'b1;
        tick(); tick(); tick(); tick();
        data_v_i = 1'b0; data_i = 32'h0;
        checks++; if (resp_v_o !== 1'b0 || cmd_ready_o !== 1'b1) begin failures++; $display("FAIL mid_after got=%0b/%0b exp=0/1", resp_v_o, cmd_ready_o); end
    endtask

    initial begin
        reset_n_i = 1'b0; cmd_v_i = 1'b0; cmd_op_i = 2'd0; cmd_vtag_i = '0; cmd_ptag_i = '0;
        cmd_u_i = 1'b0; cmd_x_i = 1'b0; translation_en_i = 1'b0; priv_i = 2'd1; poison_i = 1'b0;
        data_i = 32'h0; data_v_i = 1'b0; resp_ready_i = 1'b0;
        s1_v = 1'b0; s2_v = 1'b0; s1_d = 32'h0; s2_d = 32'h0;
        #1;
        test_reset();
        test_translation_off();
        test_translation_on();
        test_faults();
        test_replacement();
        test_back_to_back();
        test_poison();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
